// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter shared types.
// State and owner encodings for the unified memory port.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter bus bundle.
// Fetch, load/store and memory sides of the shared port.
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
) ();

  logic            if_req;
  logic [AW-1:0]   if_addr;
  logic            if_gnt;
  logic            if_rvalid;
  logic [DW-1:0]   if_rdata;

  logic            d_req;
  logic            d_we;
  logic [DW/8-1:0] d_be;
  logic [AW-1:0]   d_addr;
  logic [DW-1:0]   d_wdata;
  logic            d_gnt;
  logic            d_rvalid;
  logic [DW-1:0]   d_rdata;

  logic            mem_req;
  logic            mem_we;
  logic [DW/8-1:0] mem_be;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic            mem_gnt;
  logic            mem_rvalid;
  logic [DW-1:0]   mem_rdata;

  logic            bus_err;

  modport slave (
    input  if_req, if_addr,
    input  d_req, d_we, d_be, d_addr, d_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output if_gnt, if_rvalid, if_rdata,
    output d_gnt, d_rvalid, d_rdata,
    output mem_req, mem_we, mem_be,
    output mem_addr, mem_wdata,
    output bus_err
  );

  modport master (
    output if_req, if_addr,
    output d_req, d_we, d_be, d_addr, d_wdata,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_req, mem_we, mem_be,
    input  mem_addr, mem_wdata,
    input  bus_err
  );

endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin pick.
// The requester that did not win last time wins a tie.
module rr_arb2
  import mem_arbiter_pkg::*;
(
  input  logic   req_if,
  input  logic   req_d,
  input  owner_t last_owner,
  output logic   grant_valid,
  output owner_t winner
);

  // pick a winner among pending requests
  always_comb begin
    grant_valid = req_if | req_d;
    winner      = OWN_IF;
    unique case (1'b1)
      (req_if & req_d):
        winner = (last_owner == OWN_IF) ? OWN_D : OWN_IF;
      (req_d & ~req_if):
        winner = OWN_D;
      default:
        winner = OWN_IF;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Fetch / load-store arbiter onto one memory port.
// One outstanding transaction, round-robin, response timeout.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 15
) (
  input logic           clk,
  input logic           reset,
  mem_arbiter_if.slave  bus
);

  localparam int BW = DW / 8;
  localparam int CW = $clog2(TIMEOUT + 1);

  state_t        state;
  owner_t        owner;
  owner_t        last_owner;
  logic          lat_we;
  logic [BW-1:0] lat_be;
  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_wdata;
  logic [CW-1:0] cnt;
  logic          berr;

  logic          pick_v;
  owner_t        pick;
  logic          in_req;
  logic          in_resp;
  logic          acc;
  logic          fin_ok;
  logic          fin_to;
  logic          fire;
  logic [DW-1:0] rdata;

  rr_arb2 u_rr (
    .req_if      (bus.if_req),
    .req_d       (bus.d_req),
    .last_owner  (last_owner),
    .grant_valid (pick_v),
    .winner      (pick)
  );

  assign in_req  = (state == REQ);
  assign in_resp = (state == RESP);
  assign acc     = in_req & bus.mem_gnt;
  assign fin_ok  = (acc | in_resp) & bus.mem_rvalid;
  assign fin_to  = in_resp & ~bus.mem_rvalid
                 & (cnt == CW'(TIMEOUT));
  assign fire    = fin_ok | fin_to;
  assign rdata   = fin_ok ? bus.mem_rdata : '0;

  assign bus.mem_req   = in_req;
  assign bus.mem_we    = in_req & lat_we;
  assign bus.mem_be    = in_req ? lat_be : '0;
  assign bus.mem_addr  = in_req ? lat_addr : '0;
  assign bus.mem_wdata = in_req ? lat_wdata : '0;

  assign bus.if_gnt    = acc & (owner == OWN_IF);
  assign bus.d_gnt     = acc & (owner == OWN_D);
  assign bus.if_rvalid = fire & (owner == OWN_IF);
  assign bus.d_rvalid  = fire & (owner == OWN_D);
  assign bus.if_rdata  = (owner == OWN_IF) ? rdata : '0;
  assign bus.d_rdata   = (owner == OWN_D) ? rdata : '0;
  assign bus.bus_err   = berr;

  // transaction FSM: arbitrate, request, await response
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      owner      <= OWN_IF;
      last_owner <= OWN_D;
      lat_we     <= 1'b0;
      lat_be     <= '0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      cnt        <= '0;
      berr       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (pick_v) begin
            owner      <= pick;
            last_owner <= pick;
            state      <= REQ;
            if (pick == OWN_D) begin
              lat_we    <= bus.d_we;
              lat_be    <= bus.d_be;
              lat_addr  <= bus.d_addr;
              lat_wdata <= bus.d_wdata;
            end else begin
              lat_we    <= 1'b0;
              lat_be    <= '1;
              lat_addr  <= bus.if_addr;
              lat_wdata <= '0;
            end
          end
        end
        REQ: begin
          if (acc) begin
            state <= bus.mem_rvalid ? IDLE : RESP;
          end
        end
        RESP: begin
          if (fire) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
      if (fin_to) begin
        berr <= 1'b1;
      end
    end
  end

endmodule
